// File: rtl/dcache_2way.sv
// dcache_2way: two-way set-associative write-back data cache with LRU replacement.
// The cpu side and the memory side both use BUSYWAIT-style stalls.
// Optional build macro DCACHE_STATS_EN adds the HIT_COUNT and MISS_COUNT
// outputs. Both are saturating 16-bit counters.
module dcache_2way #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int SETS   = 4
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              READ,
  input  logic                              WRITE,
  input  logic [ADDR_W-1:0]                 ADDRESS,
  input  logic [DATA_W-1:0]                 WRITEDATA,
  output logic [DATA_W-1:0]                 READDATA,
  output logic                              BUSYWAIT,
  output logic                              mem_read,
  output logic                              mem_write,
  output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_address,
  output logic [DATA_W*WORDS-1:0]           mem_writedata,
  input  logic [DATA_W*WORDS-1:0]           mem_readdata,
  input  logic                              mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                       HIT_COUNT,
  output logic [15:0]                       MISS_COUNT
`endif
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int BLK_W = DATA_W * WORDS;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t state_q, state_d;

  logic [1:0]       valid_q [SETS];
  logic [1:0]       dirty_q [SETS];
  logic [SETS-1:0]  lru_q;
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [BLK_W-1:0] data_q  [SETS][2];
  logic [BLK_W-1:0] fill_q;

  logic [TAG_W-1:0] reqTag;
  logic [IDX_W-1:0] reqIdx;
  logic [OFF_W-1:0] reqOff;
  logic             req;
  logic             hit0;
  logic             hit1;
  logic             hit;
  logic             hitWay;
  logic             victim;
  logic             victimDirty;
  logic [BLK_W-1:0] hitBlock;

  assign reqTag      = ADDRESS[ADDR_W-1 -: TAG_W];
  assign reqIdx      = ADDRESS[OFF_W +: IDX_W];
  assign reqOff      = ADDRESS[OFF_W-1:0];
  assign req         = READ | WRITE;
  assign hit0        = valid_q[reqIdx][0] && (tag_q[reqIdx][0] == reqTag);
  assign hit1        = valid_q[reqIdx][1] && (tag_q[reqIdx][1] == reqTag);
  assign hit         = hit0 | hit1;
  assign hitWay      = hit1;
  assign hitBlock    = data_q[reqIdx][hitWay];
  assign victimDirty = valid_q[reqIdx][victim] && dirty_q[reqIdx][victim];

  // Victim choice: fill an empty way first (way 0 before way 1), else evict the LRU way
  always_comb begin
    victim = lru_q[reqIdx];
    if (!valid_q[reqIdx][0]) begin
      victim = 1'b0;
    end else if (!valid_q[reqIdx][1]) begin
      victim = 1'b1;
    end
  end

  // Miss-handling FSM next state plus cpu/memory handshake outputs
  always_comb begin
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    READDATA      = '0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = {reqTag, reqIdx};
    mem_writedata = '0;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          BUSYWAIT = 1'b1;
          state_d  = victimDirty ? WRITEBACK : FETCH;
        end else if (READ && !WRITE && hit) begin
          READDATA = hitBlock[int'(reqOff)*DATA_W +: DATA_W];
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_q[reqIdx][victim], reqIdx};
        mem_writedata = data_q[reqIdx][victim];
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        BUSYWAIT = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!RESET) BUSYWAIT = 1'b0;
  end

  // State register plus the per-way valid/dirty flags and per-set LRU bit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= IDLE;
      lru_q   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req && hit) begin
        lru_q[reqIdx] <= ~hitWay;
        if (WRITE) dirty_q[reqIdx][hitWay] <= 1'b1;
      end else if (state_q == UPDATE) begin
        valid_q[reqIdx][victim] <= 1'b1;
        dirty_q[reqIdx][victim] <= 1'b0;
        lru_q[reqIdx]           <= ~victim;
      end
    end
  end

  // Tag and data storage; nothing is written while reset holds the FSM idle with all ways invalid
  always_ff @(posedge CLK) begin
    if (state_q == IDLE && WRITE && hit) begin
      data_q[reqIdx][hitWay][int'(reqOff)*DATA_W +: DATA_W] <= WRITEDATA;
    end else if (state_q == FETCH && !mem_busywait) begin
      fill_q <= mem_readdata;
    end else if (state_q == UPDATE) begin
      data_q[reqIdx][victim] <= fill_q;
      tag_q[reqIdx][victim]  <= reqTag;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        afterMiss_q;
  logic [15:0] hitCount_q;
  logic [15:0] missCount_q;

  // Saturating counters; the hit that completes a miss is not counted as a hit
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      afterMiss_q <= 1'b0;
      hitCount_q  <= '0;
      missCount_q <= '0;
    end else if (state_q == IDLE && req) begin
      if (!hit) begin
        if (missCount_q != 16'hFFFF) missCount_q <= missCount_q + 16'd1;
      end else if (afterMiss_q) begin
        afterMiss_q <= 1'b0;
      end else if (hitCount_q != 16'hFFFF) begin
        hitCount_q <= hitCount_q + 16'd1;
      end
    end else if (state_q == UPDATE) begin
      afterMiss_q <= 1'b1;
    end
  end

  assign HIT_COUNT  = hitCount_q;
  assign MISS_COUNT = missCount_q;
`endif

endmodule
